// File: rtl/dispense_sequencer.sv
// Dispense sequencer: meters portions by counting timer ticks, then settles.
// Watchdog faults the run if ticks stop arriving while the gate is active.
module dispense_sequencer #(
  parameter int PORTION_W         = 4,
  parameter int TICKS_PER_PORTION = 2,
  parameter int SETTLE_TICKS      = 1,
  parameter int TICK_TIMEOUT      = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PORTION_W-1:0] portions,
  input  logic                 abort,
  input  logic                 tick,
  output logic                 timer_en,
  output logic                 gate_open,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [PORTION_W-1:0] remaining
);

  localparam int TC_W = $clog2(TICKS_PER_PORTION) + 1;
  localparam int SC_W = $clog2(SETTLE_TICKS) + 1;
  localparam int WD_W = $clog2(TICK_TIMEOUT + 1);

  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICKS_PER_PORTION - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_TICKS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TICK_TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [PORTION_W-1:0] ONE = PORTION_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPENSE,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } state_e;

  state_e               state_q, state_d;
  logic                 timer_en_q, timer_en_d;
  logic                 gate_open_q, gate_open_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [PORTION_W-1:0] remaining_q, remaining_d;
  logic [TC_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [SC_W-1:0]      settle_cnt_q, settle_cnt_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic [WD_W-1:0]      wdog_inc;
  logic                 wdog_hit;

  assign timer_en  = timer_en_q;
  assign gate_open = gate_open_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign remaining = remaining_q;

  assign wdog_inc = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WD_W'(1);
  // The cycle that would bring the watchdog to TICK_TIMEOUT faults.
  assign wdog_hit = (wdog_q >= WD_LAST);

  always_comb begin
    state_d      = state_q;
    timer_en_d   = timer_en_q;
    gate_open_d  = gate_open_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    remaining_d  = remaining_q;
    tick_cnt_d   = tick_cnt_q;
    settle_cnt_d = settle_cnt_q;
    wdog_d       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (portions != '0) begin
            state_d      = S_DISPENSE;
            remaining_d  = portions;
            gate_open_d  = 1'b1;
            timer_en_d   = 1'b1;
            busy_d       = 1'b1;
            tick_cnt_d   = '0;
            settle_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        if (abort) begin
          state_d     = S_IDLE;
          gate_open_d = 1'b0;
          timer_en_d  = 1'b0;
          busy_d      = 1'b0;
          remaining_d = '0;
        end else if (tick) begin
          if (tick_cnt_q == TC_LAST) begin
            tick_cnt_d = '0;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - ONE;
            end
            if (remaining_q == ONE) begin
              state_d      = S_SETTLE;
              gate_open_d  = 1'b0;
              settle_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TC_W'(1);
          end
        end else if (wdog_hit) begin
          state_d     = S_FAULT;
          gate_open_d = 1'b0;
          timer_en_d  = 1'b0;
          busy_d      = 1'b0;
          error_d     = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d     = S_IDLE;
          gate_open_d = 1'b0;
          timer_en_d  = 1'b0;
          busy_d      = 1'b0;
          remaining_d = '0;
        end else if (tick) begin
          if (settle_cnt_q == SC_LAST) begin
            state_d    = S_DONE;
            timer_en_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + SC_W'(1);
          end
        end else if (wdog_hit) begin
          state_d     = S_FAULT;
          gate_open_d = 1'b0;
          timer_en_d  = 1'b0;
          busy_d      = 1'b0;
          error_d     = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_FAULT: begin
        if (abort) begin
          state_d     = S_IDLE;
          error_d     = 1'b0;
          remaining_d = '0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        gate_open_d = 1'b0;
        timer_en_d  = 1'b0;
        busy_d      = 1'b0;
        error_d     = 1'b0;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_en_q   <= 1'b0;
      gate_open_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      remaining_q  <= '0;
      tick_cnt_q   <= '0;
      settle_cnt_q <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_en_q   <= timer_en_d;
      gate_open_q  <= gate_open_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      remaining_q  <= remaining_d;
      tick_cnt_q   <= tick_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: per-scenario tasks with a remaining-value
// scoreboard fed by the stimulus and drained as the DUT changes remaining.
module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] portions;
  logic       abort;
  logic       tick;
  logic       timer_en;
  logic       gate_open;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] remaining;

  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  logic [3:0] last_rem = 4'd0;
  logic [3:0] exp_q[$];

  dispense_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .portions  (portions),
    .abort     (abort),
    .tick      (tick),
    .timer_en  (timer_en),
    .gate_open (gate_open),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one cycle; a change of remaining pops the scoreboard.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (remaining !== last_rem) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_rem unexpected remaining=%0d", remaining);
      end else begin
        e = exp_q.pop_front();
        if (remaining !== e) begin
          fails++;
          $display("FAIL sb_rem got %0d expected %0d", remaining, e);
        end
      end
      last_rem = remaining;
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    portions = 4'd0;
    abort = 1'b0;
    tick = 1'b0;
    step();
    step();
    tests++;
    if ({timer_en, gate_open, busy, done, error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b expected 00000",
               {timer_en, gate_open, busy, done, error});
    end
    tests++;
    if (remaining !== 4'd0) begin
      fails++;
      $display("FAIL reset_rem got %0d expected 0", remaining);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    start = 1'b1;
    portions = 4'd3;
    exp_q.push_back(4'd3);
    step();
    start = 1'b0;
    tests++;
    if ({gate_open, timer_en, busy} !== 3'b111) begin
      fails++;
      $display("FAIL basic_open got %b expected 111",
               {gate_open, timer_en, busy});
    end
    for (int k = 1; k <= 7; k++) begin
      repeat (500) step();
      if (k == 2) exp_q.push_back(4'd2);
      if (k == 4) exp_q.push_back(4'd1);
      if (k == 6) exp_q.push_back(4'd0);
      pulse_tick();
      if (k == 6) begin
        tests++;
        if ({gate_open, timer_en, busy, done} !== 4'b0110) begin
          fails++;
          $display("FAIL basic_settle got %b expected 0110",
                   {gate_open, timer_en, busy, done});
        end
      end
    end
    tests++;
    if ({done, timer_en, busy, gate_open} !== 4'b1000) begin
      fails++;
      $display("FAIL basic_done got %b expected 1000",
               {done, timer_en, busy, gate_open});
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_width got %b expected 0", done);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL basic_drain pending %0d expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero_request();
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    portions = 4'd0;
    step();
    start = 1'b0;
    tests++;
    if ({done, gate_open, timer_en, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL zero_pulse got %b expected 1000",
               {done, gate_open, timer_en, busy});
    end
    step();
    step();
    tests++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_count got %0d expected %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    portions = 4'd5;
    exp_q.push_back(4'd5);
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      repeat (10) step();
      if (k == 2) exp_q.push_back(4'd4);
      pulse_tick();
    end
    abort = 1'b1;
    exp_q.push_back(4'd0);
    step();
    abort = 1'b0;
    tests++;
    if ({gate_open, timer_en, busy} !== 3'b000 || remaining !== 4'd0) begin
      fails++;
      $display("FAIL abort_state got %b rem %0d expected 000 rem 0",
               {gate_open, timer_en, busy}, remaining);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (5) step();
      pulse_tick();
    end
    tests++;
    if (done_cnt !== d0 || remaining !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_after got done %0d rem %0d expected done 0 rem 0",
               done_cnt - d0, remaining);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL abort_drain pending %0d expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_watchdog();
    start = 1'b1;
    portions = 4'd2;
    exp_q.push_back(4'd2);
    step();
    start = 1'b0;
    repeat (1022) step();
    tests++;
    if (error !== 1'b0 || gate_open !== 1'b1) begin
      fails++;
      $display("FAIL wd_early got err %b gate %b expected err 0 gate 1",
               error, gate_open);
    end
    step();
    tests++;
    if ({error, gate_open, timer_en, busy} !== 4'b1000 ||
        remaining !== 4'd2) begin
      fails++;
      $display("FAIL wd_fault got %b rem %0d expected 1000 rem 2",
               {error, gate_open, timer_en, busy}, remaining);
    end
    start = 1'b1;
    portions = 4'd9;
    step();
    start = 1'b0;
    step();
    tests++;
    if (error !== 1'b1 || remaining !== 4'd2 || gate_open !== 1'b0) begin
      fails++;
      $display("FAIL wd_start_ign got err %b rem %0d expected err 1 rem 2",
               error, remaining);
    end
    abort = 1'b1;
    exp_q.push_back(4'd0);
    step();
    abort = 1'b0;
    tests++;
    if (error !== 1'b0 || remaining !== 4'd0) begin
      fails++;
      $display("FAIL wd_clear got err %b rem %0d expected err 0 rem 0",
               error, remaining);
    end
    start = 1'b1;
    portions = 4'd2;
    exp_q.push_back(4'd2);
    step();
    start = 1'b0;
    repeat (1022) step();
    pulse_tick();
    tests++;
    if (error !== 1'b0 || gate_open !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wd_tick_save got err %b gate %b expected err 0 gate 1",
               error, gate_open);
    end
    abort = 1'b1;
    exp_q.push_back(4'd0);
    step();
    abort = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wd_drain pending %0d expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_priority();
    start = 1'b1;
    portions = 4'd4;
    exp_q.push_back(4'd4);
    step();
    portions = 4'd9;
    step();
    start = 1'b0;
    tests++;
    if (remaining !== 4'd4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_start got rem %0d expected 4", remaining);
    end
    pulse_tick();
    tick = 1'b1;
    abort = 1'b1;
    exp_q.push_back(4'd0);
    step();
    tick = 1'b0;
    abort = 1'b0;
    tests++;
    if ({gate_open, timer_en, busy} !== 3'b000 || remaining !== 4'd0) begin
      fails++;
      $display("FAIL prio_abort got %b rem %0d expected 000 rem 0",
               {gate_open, timer_en, busy}, remaining);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL prio_drain pending %0d expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_settle();
    int d0;
    start = 1'b1;
    portions = 4'd1;
    exp_q.push_back(4'd1);
    step();
    start = 1'b0;
    repeat (3) step();
    pulse_tick();
    repeat (3) step();
    exp_q.push_back(4'd0);
    pulse_tick();
    tests++;
    if ({gate_open, timer_en, busy} !== 3'b011) begin
      fails++;
      $display("FAIL settle_entry got %b expected 011",
               {gate_open, timer_en, busy});
    end
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({timer_en, gate_open, busy, done, error} !== 5'b0 ||
        remaining !== 4'd0) begin
      fails++;
      $display("FAIL async_reset got %b rem %0d expected 00000 rem 0",
               {timer_en, gate_open, busy, done, error}, remaining);
    end
    #3;
    rst_n = 1'b1;
    pulse_tick();
    repeat (5) step();
    tests++;
    if (done_cnt !== d0 || busy !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got done %0d busy %b expected done 0 busy 0",
               done_cnt - d0, busy);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_drain pending %0d expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_request();
    test_abort();
    test_watchdog();
    test_priority();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
